// File: rtl/solver_dispatch.sv
// solver_dispatch: hands problem indices round-robin to NUM_ENG solver engines and counts fits.
// Optional per-engine watchdog is compiled in when SOLVER_WATCHDOG_EN is defined.
module solver_dispatch #(
    parameter int          NUM_ENG  = 4,
    parameter int          IDX_W    = 16,
    parameter int          CNT_W    = 64,
    parameter logic [31:0] WDOG_CYC = 32'd1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   num_probs,
    output logic [NUM_ENG-1:0] eng_start,
    output logic [IDX_W-1:0]   eng_prob,
    input  logic [NUM_ENG-1:0] eng_busy,
    input  logic [NUM_ENG-1:0] eng_done,
    input  logic [NUM_ENG-1:0] eng_fit,
    output logic [CNT_W-1:0]   total_count,
    output logic [IDX_W-1:0]   timeouts,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int EW = NUM_ENG > 1 ? $clog2(NUM_ENG) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_DISPATCH = 2'd1, S_DRAIN = 2'd2, S_FINISH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   num_q, num_d, next_idx_q, next_idx_d, prob_q, prob_d;
    logic [NUM_ENG-1:0] owned_q, owned_d, start_q, start_d;
    logic [EW-1:0]      rr_q, rr_d, sel, idx;
    logic [CNT_W-1:0]   total_q, total_d;
    logic               done_q, done_d, err_q, err_d;
    logic               go, want, found;
    logic [NUM_ENG-1:0] qual, elig, pick, expired, blocked;
    logic [CNT_W:0]     sum;
    int                 fits, j;

    assign go   = start && (state_q == S_IDLE || state_q == S_FINISH);
    assign want = state_q == S_DISPATCH && next_idx_q < num_q;
    assign qual = eng_done & owned_q;
    // Eligibility uses registered ownership, so a finishing engine is reusable only next cycle.
    assign elig = ~owned_q & ~eng_busy & ~blocked;

    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = '0;
        j = 0;
        for (int k = 0; k < NUM_ENG; k++) begin
            j = int'(rr_q) + k;
            j = j >= NUM_ENG ? j - NUM_ENG : j;
            idx = EW'(j);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
        pick = want && found ? NUM_ENG'(1) << sel : '0;
        fits = $countones(qual & eng_fit);
        sum = {1'b0, total_q} + (CNT_W+1)'(fits);
        state_d = go ? S_DISPATCH
                : state_q == S_DISPATCH && next_idx_q == num_q ? S_DRAIN
                : state_q == S_DRAIN && owned_q == '0 ? S_FINISH
                : state_q;
        num_d = go ? num_probs : num_q;
        next_idx_d = go ? '0 : next_idx_q + IDX_W'(pick != '0);
        rr_d = pick == '0 ? rr_q : sel == EW'(NUM_ENG - 1) ? '0 : sel + EW'(1);
        owned_d = (owned_q & ~qual & ~expired) | pick;
        start_d = pick;
        prob_d = pick != '0 ? next_idx_q : prob_q;
        total_d = go ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        done_d = go ? 1'b0 : state_q == S_DRAIN && owned_q == '0 ? 1'b1 : done_q;
        err_d = (err_q && !go) || (eng_done & ~owned_q) != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            next_idx_q <= '0;
            prob_q     <= '0;
            owned_q    <= '0;
            start_q    <= '0;
            rr_q       <= '0;
            total_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            next_idx_q <= next_idx_d;
            prob_q     <= prob_d;
            owned_q    <= owned_d;
            start_q    <= start_d;
            rr_q       <= rr_d;
            total_q    <= total_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef SOLVER_WATCHDOG_EN
    logic [31:0]        wcnt_q [NUM_ENG];
    logic [NUM_ENG-1:0] stale_q;
    logic [IDX_W-1:0]   to_q;

    // A real completion in the expiry cycle wins over the timeout.
    always_comb begin
        expired = '0;
        for (int k = 0; k < NUM_ENG; k++)
            expired[k] = owned_q[k] && !eng_done[k] && wcnt_q[k] >= WDOG_CYC - 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ENG; k++) wcnt_q[k] <= '0;
            stale_q <= '0;
            to_q    <= '0;
        end else begin
            for (int k = 0; k < NUM_ENG; k++)
                wcnt_q[k] <= pick[k] ? 32'd0 : owned_q[k] ? wcnt_q[k] + 32'd1 : wcnt_q[k];
            stale_q <= expired | (stale_q & eng_busy);
            to_q    <= go ? '0 : to_q + IDX_W'($countones(expired));
        end
    end

    assign blocked  = stale_q;
    assign timeouts = to_q;
`else
    assign expired  = '0;
    assign blocked  = '0;
    assign timeouts = '0;
`endif

    assign eng_start   = start_q;
    assign eng_prob    = prob_q;
    assign total_count = total_q;
    assign busy        = state_q == S_DISPATCH || state_q == S_DRAIN;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_solver_dispatch.sv
// tb_solver_dispatch: engine-model bench with a dispatch/result scoreboard for solver_dispatch.
module tb_solver_dispatch;
    localparam int NE = 4;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0]   num_probs = '0;
    logic [NE-1:0] eng_start, eng_busy, eng_done, eng_fit;
    logic [15:0]   eng_prob, timeouts;
    logic [63:0]   total_count;
    logic          busy, done, err;

    logic [NE-1:0] resp_busy = '0, resp_done = '0, resp_fit = '0, hold_busy = '0, inj_done = '0;
    int            rem [NE];
    int            prob [NE];
    int            lat_cfg [NE];
    bit            lat_rand = 1'b0;
    bit [63:0]     fit_tab;
    int            checks = 0, errors = 0;
    bit            done_prev = 1'b0;

    typedef struct { int idx; int eng; } disp_t;
    disp_t         exp_disp [$];
    longint        exp_res [$];
    disp_t         d;

    assign eng_busy = resp_busy | hold_busy;
    assign eng_done = resp_done | inj_done;
    assign eng_fit  = resp_fit;

    always #5 clk = ~clk;

    solver_dispatch dut (
        .clk(clk), .rst(rst), .start(start), .num_probs(num_probs),
        .eng_start(eng_start), .eng_prob(eng_prob), .eng_busy(eng_busy),
        .eng_done(eng_done), .eng_fit(eng_fit), .total_count(total_count),
        .timeouts(timeouts), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor pops the scoreboard, then the engine models react to this cycle's dispatches.
    always @(negedge clk) begin
        if (eng_start != '0) begin
            check("eng_start one-hot", 64'($onehot(eng_start)), 1);
            check("dispatch to busy engine", 64'(eng_start & (resp_busy | hold_busy)), 0);
            if (exp_disp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected dispatch: prob %0d mask %b, none expected", eng_prob, eng_start);
            end else begin
                d = exp_disp.pop_front();
                check("eng_prob", 64'(eng_prob), 64'(d.idx));
                if (d.eng >= 0) check("rr engine", 64'(eng_start), 64'(1) << d.eng);
            end
        end
        if (done && !done_prev) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected done: total %0d, no run expected", total_count);
            end else begin
                check("total_count", total_count, 64'(exp_res.pop_front()));
                check("timeouts", 64'(timeouts), 0);
                check("err at done", 64'(err), 0);
            end
        end
        done_prev = done;
        resp_done = '0;
        resp_fit = '0;
        for (int e = 0; e < NE; e++) begin
            if (rem[e] > 0) begin
                rem[e]--;
                if (rem[e] == 0) begin
                    resp_done[e] = 1'b1;
                    resp_fit[e] = fit_tab[prob[e]];
                    resp_busy[e] = 1'b0;
                end
            end
            if (eng_start[e]) begin
                prob[e] = int'(eng_prob);
                rem[e] = lat_rand ? int'($urandom_range(1, 8)) : lat_cfg[e];
                resp_busy[e] = 1'b1;
            end
        end
    end

    // Expected engine for problem i is off + (base + i) % span; span 0 skips the engine check.
    task automatic run(input int n, input int off, input int base, input int span,
                       input bit glitch, output int cyc);
        longint t = 0;
        for (int i = 0; i < n; i++) begin
            exp_disp.push_back('{idx: i, eng: span > 0 ? off + (base + i) % span : -1});
            t += longint'(fit_tab[i]);
        end
        exp_res.push_back(t);
        @(posedge clk); #1;
        start = 1'b1;
        num_probs = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        num_probs = 16'($urandom);
        @(negedge clk);
        cyc = 1;
        check("busy after start", 64'(busy), 1);
        while (!done && cyc < 2000) begin
            start = glitch && cyc == 3;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        #1;
        check("run completes", 64'(done), 1);
        check("all dispatched", 64'(exp_disp.size()), 0);
        check("result consumed", 64'(exp_res.size()), 0);
        exp_disp.delete();
        exp_res.delete();
    endtask

    initial begin
        int cyc;
        int n;
        foreach (lat_cfg[i]) lat_cfg[i] = 5;
        repeat (3) @(negedge clk);
        check("reset eng_start", 64'(eng_start), 0);
        check("reset eng_prob", 64'(eng_prob), 0);
        check("reset total", total_count, 0);
        check("reset timeouts", 64'(timeouts), 0);
        check("reset busy", 64'(busy), 0);
        check("reset done", 64'(done), 0);
        check("reset err", 64'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        @(posedge clk); #1;
        inj_done = 4'b1000;
        @(posedge clk); #1;
        inj_done = '0;
        @(negedge clk);
        check("err after stray done", 64'(err), 1);
        check("total after stray done", total_count, 0);

        for (int i = 0; i < 64; i++) fit_tab[i] = (i % 2 == 0);
        run(10, 0, 0, 4, 1'b0, cyc);
        check("even-fit total", total_count, 5);
        check("err cleared by start", 64'(err), 0);

        run(0, 0, 0, 4, 1'b0, cyc);
        check("empty run done edge", 64'(cyc), 3);
        check("empty run total", total_count, 0);

        // Pointer sits at engine 2; engines 1 and 2 are timed to complete together.
        fit_tab = '1;
        lat_cfg = '{5, 6, 9, 5};
        fork
            run(4, 0, 2, 4, 1'b0, cyc);
            begin
                logic [63:0] t0;
                int w;
                w = 0;
                while (eng_done !== 4'b0110 && w < 200) begin
                    @(negedge clk); #1;
                    w++;
                end
                t0 = total_count;
                @(negedge clk); #1;
                check("dual done adds two", total_count, t0 + 2);
            end
        join
        check("all-fit total", total_count, 4);

        lat_cfg = '{5, 5, 5, 5};
        fit_tab = {$urandom, $urandom};
        hold_busy = 4'b0001;
        run(6, 1, 1, 3, 1'b0, cyc);
        hold_busy = '0;

        lat_rand = 1'b1;
        for (int r = 0; r < 20; r++) begin
            fit_tab = {$urandom, $urandom};
            hold_busy = $urandom_range(0, 3) == 0 ? NE'(1) << $urandom_range(0, NE - 1) : '0;
            n = int'($urandom_range(0, 40));
            run(n, 0, 0, 0, 1'b1, cyc);
        end
        hold_busy = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/solver_dispatch.md
# solver_dispatch

Problem scheduler for the day-12 packing solver: accepts a run request for `num_probs` problems, hands problem indices out round-robin to `NUM_ENG` independent backtracking solver engines, collects each engine's fit/no-fit verdict and accumulates the count of problems that fit. It sits between the top-level run control and the engine array, replacing the single-engine sequential problem loop.

## Interface

- `NUM_ENG`, 4, number of solver engines (1..16)
- `IDX_W`, 16, problem index / count width
- `CNT_W`, 64, result counter width
- `WDOG_CYC`, 32'd1_000_000, watchdog limit in cycles (used only with `SOLVER_WATCHDOG_EN`)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  run request pulse; sampled only in IDLE or FINISH
- `num_probs`  in  IDX_W  problem count, sampled with `start`
- `eng_start`  out  NUM_ENG  one-hot, one-cycle dispatch pulse
- `eng_prob`  out  IDX_W  problem index, valid while `eng_start` != 0
- `eng_busy`  in  NUM_ENG  engine reports busy
- `eng_done`  in  NUM_ENG  per-engine one-cycle completion pulse
- `eng_fit`  in  NUM_ENG  verdict, qualified by `eng_done`
- `total_count`  out  CNT_W  number of problems that fit
- `timeouts`  out  IDX_W  problems abandoned by watchdog
- `busy`  out  1  run in progress
- `done`  out  1  run complete; held until next accepted `start`
- `err`  out  1  sticky: `eng_done` from an engine not owned

## Operation

- Reset: all outputs 0, state IDLE, `owned`=0, `next_idx`=0, rr pointer=0.
- States: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE/FINISH + `start`: latch `num_probs`; clear `total_count`, `timeouts`, `next_idx`, `done`, `err`; go DISPATCH. `start` in DISPATCH/DRAIN ignored.
- DISPATCH: each cycle, if `next_idx < num_probs`, pick first engine e at or after rr pointer (wrapping) with `!owned[e] && !eng_busy[e]`; next edge: `eng_start[e]`=1, `eng_prob`=`next_idx`, `owned[e]`=1, `next_idx`+1, rr pointer = e+1 mod NUM_ENG. At most one dispatch per cycle. When `next_idx == num_probs` (including 0) go DRAIN.
- Results, any state: for each e with `eng_done[e] && owned[e]`: clear `owned[e]`, add `eng_fit[e]` to `total_count`. Several engines same cycle: add popcount of qualified fits. `eng_done` with `owned[e]`=0: ignored, `err`=1.
- Eligibility uses registered `owned`: an engine finishing in cycle t cannot be re-dispatched before t+1.
- DRAIN: when `owned`==0, go FINISH, `done`=1, `busy`=0.
- `busy`=1 in DISPATCH and DRAIN.
- `total_count` saturates at all-ones; `next_idx` never exceeds latched count.
- Reset mid-run: immediate return to reset values; engines not notified.

## Timing

- `start` at edge t -> `busy`=1 after t; first `eng_start` after edge t+1 earliest.
- Back-to-back dispatch to different engines every cycle; full array loaded in NUM_ENG cycles when all idle.
- `eng_done` at cycle t -> `total_count` updated after edge t; `done` rises at edge t+1 if it was the last outstanding result and dispatch complete.
- `num_probs`=0: `done` rises two edges after accepting `start`.

## Configuration

- `SOLVER_WATCHDOG_EN` defined: per-engine cycle counter, reset at dispatch; reaching `WDOG_CYC` while owned clears `owned[e]`, increments `timeouts`, counts as no-fit. A later `eng_done` from that engine sets `err`. The engine stays ineligible until `eng_busy[e]` drops.
- Not defined: no counters, `timeouts` tied 0, engines may run unbounded.

## Test plan

- NUM_ENG=4, num_probs=10, engines finish after 5 cycles, fit on even indices -> indices 0..9 each dispatched once, round-robin 0,1,2,3,0..., `total_count`=5, `done`=1.
- num_probs=0 -> no `eng_start`, `done`=1 two edges after `start`, `total_count`=0.
- Engines 1 and 2 pulse `eng_done` with `eng_fit`=1 same cycle -> `total_count` increases by 2 in one edge.
- Engine 0 held `eng_busy`=1 throughout, num_probs=6 -> all problems go to engines 1..3, none to 0.
- Spurious `eng_done[3]` while IDLE -> `err`=1, `total_count` unchanged; cleared by next `start`.
- With `SOLVER_WATCHDOG_EN`, WDOG_CYC=20, engine 2 never responds, num_probs=4 -> `timeouts`=1, `done`=1, `total_count` counts only the other three.
